// File: rtl/ternary_serial_adder.sv
// ternary_serial_adder
//
// Trit-serial multi-trit ternary adder. Each cycle it takes one operand trit
// pair (LSB first), adds it with the stored carry using two chained 2-bit-encoded
// ternary half adders, and emits one registered sum trit.
//
// Trit encoding: 00=0, 01=1, 10=2, 11=illegal. An illegal trit is added as 0
// and sets the sticky err flag until the next start.
//
// Handshake: a side transfers on the rising edge where valid && ready are both
// high. The producer holds data stable while valid && !ready. in_ready never
// depends on in_valid, and out_valid never depends on out_ready.
//
// Optional feature macro: TERNARY_SUB_EN adds the 'sub' input (subtract mode).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   sub                 (TERNARY_SUB_EN only) subtract mode, sampled at start
//   start               begin an operation (honoured in IDLE only)
//   in_valid/in_ready   operand trit handshake
//   a_trit, b_trit      operand trits
//   out_valid/out_ready sum trit handshake
//   s_trit              registered sum trit
//   carry_out           final carry of the last completed operation
//   done                one-cycle pulse at the end of an operation
//   busy                high in RUN and DONE
//   err                 sticky illegal-trit flag for this operation
//   dbg_state           current FSM state (0=IDLE, 1=RUN, 2=DONE)
module ternary_serial_adder #(
  parameter int NTRIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef TERNARY_SUB_EN
  input  logic       sub,
`endif
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] a_trit,
  input  logic [1:0] b_trit,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] s_trit,
  output logic       carry_out,
  output logic       done,
  output logic       busy,
  output logic       err,
  output logic [1:0] dbg_state
);

  localparam int CW = (NTRIT > 1) ? $clog2(NTRIT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NTRIT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            cin;
  logic            sub_mode;

  // Ternary half adder: returns {carry, sum_trit}.
  function automatic logic [2:0] ha(input logic [1:0] x, input logic [1:0] y);
    logic [2:0] t;
    logic [2:0] r;
    t = {1'b0, x} + {1'b0, y};
    r = t - 3'd3;
    if (t >= 3'd3) ha = {1'b1, r[1:0]};
    else           ha = {1'b0, t[1:0]};
  endfunction

  // Datapath
  logic [1:0] a_v, b_v, b_eff;
  logic [2:0] ha1, ha2;
  logic       illegal;
  logic       xfer;
  logic       drain_ok;

  assign a_v     = (a_trit == 2'b11) ? 2'b00 : a_trit;
  assign b_v     = (b_trit == 2'b11) ? 2'b00 : b_trit;
  // Subtract mode uses the digit-wise complement 2-b; the +1 comes from cin.
  assign b_eff   = sub_mode ? (2'd2 - b_v) : b_v;
  assign illegal = (a_trit == 2'b11) || (b_trit == 2'b11);
  assign ha1     = ha(a_v, b_eff);
  assign ha2     = ha(ha1[1:0], {1'b0, cin});

  assign drain_ok  = !out_valid || out_ready;
  assign in_ready  = (state == RUN) && drain_ok;
  assign xfer      = in_valid && in_ready;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  // FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (xfer && (cnt == LAST_CNT)) state_nxt = DONE;
      DONE: if (drain_ok) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef TERNARY_SUB_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      sub_mode <= 1'b0;
    else if (state == IDLE && start) sub_mode <= sub;
  end
`else
  assign sub_mode = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      cin       <= 1'b0;
      err       <= 1'b0;
      s_trit    <= 2'b00;
      out_valid <= 1'b0;
      carry_out <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        cnt <= '0;
`ifdef TERNARY_SUB_EN
        cin <= sub;
`else
        cin <= 1'b0;
`endif
        err <= 1'b0;
      end
      if (xfer) begin
        s_trit    <= ha2[1:0];
        out_valid <= 1'b1;
        // The two half-adder carries are never both set (max value is 5).
        cin       <= ha1[2] | ha2[2];
        cnt       <= cnt + 1'b1;
        if (illegal) err <= 1'b1;
        if (cnt == LAST_CNT) carry_out <= ha1[2] | ha2[2];
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (state == DONE && drain_ok) done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ternary_serial_adder.sv
module tb_ternary_serial_adder;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] a_trit = 2'b00;
  logic [1:0] b_trit = 2'b00;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [1:0] s_trit;
  logic       carry_out;
  logic       done;
  logic       busy;
  logic       err;
  logic [1:0] dbg_state;
`ifdef TERNARY_SUB_EN
  logic       sub = 1'b0;
`endif

  ternary_serial_adder #(.NTRIT(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef TERNARY_SUB_EN
    .sub(sub),
`endif
    .start(start),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a_trit(a_trit),
    .b_trit(b_trit),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .s_trit(s_trit),
    .carry_out(carry_out),
    .done(done),
    .busy(busy),
    .err(err),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int start_cyc = 0;

  // Scoreboard queues
  logic [1:0] exp_q[$];
  logic [1:0] got_q[$];

  // Observations recorded by the driver for the tests to judge
  logic [2:0] stall_ir;
  logic [1:0] stall_st[3];
  logic       rec_err_start;
  logic       rec_busy_start;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) got_q.push_back(s_trit);
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  // Driver: wait (bounded) for in_ready, then let the transfer edge pass.
  task automatic send_trit(input logic [1:0] a, input logic [1:0] b);
    int n;
    a_trit = a;
    b_trit = b;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL in_ready_timeout: in_ready=%b, required 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  // Driver: full operation; av/bv hold trits LSB-first in 2-bit fields.
  task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input bit stall);
    int n;
    int d0;
    d0 = done_cnt;
    got_q.delete();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start_cyc = cyc;
    rec_err_start = err;
    rec_busy_start = busy;
    for (int i = 0; i < 4; i++) begin
      if (stall && i == 2) begin
        a_trit = av[2*i +: 2];
        b_trit = bv[2*i +: 2];
        in_valid = 1'b1;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          stall_ir[k] = in_ready;
          stall_st[k] = s_trit;
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
      send_trit(av[2*i +: 2], bv[2*i +: 2]);
    end
    in_valid = 1'b0;
    a_trit = 2'b00;
    b_trit = 2'b00;
    n = 0;
    while (done_cnt == d0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL done_timeout: done never seen, required one pulse");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready  !== 1'b0)  begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (s_trit    !== 2'b00) begin errors++; $display("FAIL rst_s_trit: got %b want 00", s_trit); end
    checks++; if (carry_out !== 1'b0)  begin errors++; $display("FAIL rst_carry_out: got %b want 0", carry_out); end
    checks++; if (done      !== 1'b0)  begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    checks++; if (busy      !== 1'b0)  begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (err       !== 1'b0)  begin errors++; $display("FAIL rst_err: got %b want 0", err); end
    checks++; if (dbg_state !== 2'd0)  begin errors++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // a=16 (1,2,1,0), b=23 (2,1,2,0): sum 39 -> trits 0,1,1,1, carry 0
  task automatic test_add_basic(input string tag);
    logic [1:0] e, g;
    int d0;
    d0 = done_cnt;
    do_op(8'b00_01_10_01, 8'b00_10_01_10, 1'b0);
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd1); exp_q.push_back(2'd1);
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin
        errors++; $display("FAIL %s_trit%0d: got none want %0d", tag, i, e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin errors++; $display("FAIL %s_trit%0d: got %0d want %0d", tag, i, g, e); end
      end
    end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL %s_carry: got %b want 0", tag, carry_out); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL %s_err: got %b want 0", tag, err); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL %s_done_pulses: got %0d want 1", tag, done_cnt - d0); end
    checks++; if (done_cyc - start_cyc !== 5) begin errors++; $display("FAIL %s_done_latency: got %0d want 5", tag, done_cyc - start_cyc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_end: got %b want 0", tag, busy); end
  endtask

  // a=b=80 (2,2,2,2): sum 160 -> trits 1,2,2,2, carry 1
  task automatic test_add_max();
    logic [1:0] e, g;
    do_op(8'b10_10_10_10, 8'b10_10_10_10, 1'b0);
    exp_q.push_back(2'd1); exp_q.push_back(2'd2); exp_q.push_back(2'd2); exp_q.push_back(2'd2);
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin
        errors++; $display("FAIL max_trit%0d: got none want %0d", i, e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin errors++; $display("FAIL max_trit%0d: got %0d want %0d", i, g, e); end
      end
    end
    checks++; if (carry_out !== 1'b1) begin errors++; $display("FAIL max_carry: got %b want 1", carry_out); end
    checks++; if (rec_busy_start !== 1'b1) begin errors++; $display("FAIL max_busy_run: got %b want 1", rec_busy_start); end
  endtask

  // First case with a 3-cycle sink stall after the second sum trit
  task automatic test_stall();
    logic [1:0] e, g;
    do_op(8'b00_01_10_01, 8'b00_10_01_10, 1'b1);
    for (int k = 0; k < 3; k++) begin
      checks++; if (stall_ir[k] !== 1'b0) begin errors++; $display("FAIL stall_in_ready%0d: got %b want 0", k, stall_ir[k]); end
      checks++; if (stall_st[k] !== 2'd1) begin errors++; $display("FAIL stall_s_trit%0d: got %0d want 1", k, stall_st[k]); end
    end
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd1); exp_q.push_back(2'd1);
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin
        errors++; $display("FAIL stall_trit%0d: got none want %0d", i, e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin errors++; $display("FAIL stall_trit%0d: got %0d want %0d", i, g, e); end
      end
    end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL stall_carry: got %b want 0", carry_out); end
    checks++; if (done_cyc - start_cyc !== 8) begin errors++; $display("FAIL stall_done_latency: got %0d want 8", done_cyc - start_cyc); end
  endtask

  // a trits 1,11,1,0 (11 read as 0), b 2,1,2,0 -> trits 0,2,0,1, carry 0, err sticky
  task automatic test_illegal();
    logic [1:0] e, g;
    do_op(8'b00_01_11_01, 8'b00_10_01_10, 1'b0);
    exp_q.push_back(2'd0); exp_q.push_back(2'd2); exp_q.push_back(2'd0); exp_q.push_back(2'd1);
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin
        errors++; $display("FAIL illegal_trit%0d: got none want %0d", i, e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin errors++; $display("FAIL illegal_trit%0d: got %0d want %0d", i, g, e); end
      end
    end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL illegal_carry: got %b want 0", carry_out); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal_err_sticky: got %b want 1", err); end
  endtask

  // Next operation after the illegal one must start with err cleared
  task automatic test_err_clear();
    do_op(8'b10_10_10_10, 8'b10_10_10_10, 1'b0);
    checks++; if (rec_err_start !== 1'b0) begin errors++; $display("FAIL err_clear_start: got %b want 0", rec_err_start); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear_end: got %b want 0", err); end
    checks++; if (carry_out !== 1'b1) begin errors++; $display("FAIL err_clear_carry: got %b want 1", carry_out); end
  endtask

  // Reset after two transfers, then the first case must repeat exactly
  task automatic test_reset_mid();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    send_trit(2'd1, 2'd2);
    send_trit(2'd2, 2'd1);
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL mid_rst_out_valid: got %b want 0", out_valid); end
    checks++; if (s_trit    !== 2'b00) begin errors++; $display("FAIL mid_rst_s_trit: got %b want 00", s_trit); end
    checks++; if (carry_out !== 1'b0)  begin errors++; $display("FAIL mid_rst_carry: got %b want 0", carry_out); end
    checks++; if (busy      !== 1'b0)  begin errors++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    checks++; if (in_ready  !== 1'b0)  begin errors++; $display("FAIL mid_rst_in_ready: got %b want 0", in_ready); end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_add_basic("after_rst");
  endtask

`ifdef TERNARY_SUB_EN
  // 16 - 23 = -7 = 74 mod 81 -> trits 2,0,2,2, carry 0 (borrow)
  task automatic test_sub();
    logic [1:0] e, g;
    sub = 1'b1;
    do_op(8'b00_01_10_01, 8'b00_10_01_10, 1'b0);
    sub = 1'b0;
    exp_q.push_back(2'd2); exp_q.push_back(2'd0); exp_q.push_back(2'd2); exp_q.push_back(2'd2);
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin
        errors++; $display("FAIL sub_trit%0d: got none want %0d", i, e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin errors++; $display("FAIL sub_trit%0d: got %0d want %0d", i, g, e); end
      end
    end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL sub_carry: got %b want 0", carry_out); end
  endtask
`endif

  initial begin
    test_reset();
    test_add_basic("basic");
    test_add_max();
    test_stall();
    test_illegal();
    test_err_clear();
    test_reset_mid();
`ifdef TERNARY_SUB_EN
    test_sub();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
